link_port: RTL and testbench

- Per-direction router port sitting directly upstream and downstream of the torus connector.
- Buffers outgoing flits from the router switch and drives one PORT_SIZE link bundle into the connector's data_i slice.
- Receives the connector's data_o slice for that port, buffers incoming flits and presents them to the switch.
- Link flow control uses a registered ready bit carried inside the bundle. Four instances per node: ports 0..3.

---
 rtl/link_port.sv | 113 +++++++++++
 tb/tb_link_port.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/link_port.sv
// Router link port: TX/RX flit FIFOs between the switch and one torus connector slice,
// with a registered ready bit for link credit. Optional counters under LINK_PORT_STATS_EN.
module link_port #(
  parameter int unsigned PORT_SIZE = 39,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PORT_SIZE-3:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [PORT_SIZE-3:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [PORT_SIZE-1:0] link_o,
  input  logic [PORT_SIZE-1:0] link_i,
  output logic                 rx_ovf_o
`ifdef LINK_PORT_STATS_EN
  ,
  output logic [15:0]          tx_cnt_o,
  output logic [15:0]          rx_cnt_o
`endif
);

  localparam int unsigned FLIT_W = PORT_SIZE - 2;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic [FLIT_W-1:0] tx_mem [DEPTH];
  logic [FLIT_W-1:0] rx_mem [DEPTH];
  logic [PTR_W-1:0]  tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CNT_W-1:0]  tx_count, rx_count, tx_count_nxt, rx_count_nxt;

  logic              link_ready_q, link_valid_q;
  logic [FLIT_W-1:0] link_flit_q;

  logic peer_ready, rx_in_valid;
  logic tx_push, tx_pop, rx_push, rx_pop, rx_full, rx_drop;

  assign peer_ready  = link_i[PORT_SIZE-1];
  assign rx_in_valid = link_i[PORT_SIZE-2];

  // Full means no accept even if a pop happens this cycle (no bypass).
  assign tx_ready_o = !rst_i && (tx_count != CNT_W'(DEPTH));
  assign tx_push    = tx_valid_i && tx_ready_o;
  assign tx_pop     = (tx_count != '0) && peer_ready;

  assign rx_valid_o = (rx_count != '0);
  assign rx_data_o  = rx_mem[rx_rd_ptr];
  assign rx_pop     = rx_valid_o && rx_ready_i;
  assign rx_full    = (rx_count == CNT_W'(DEPTH));
  assign rx_push    = rx_in_valid && (!rx_full || rx_pop);
  assign rx_drop    = rx_in_valid && rx_full && !rx_pop;

  assign link_o = {link_ready_q, link_valid_q, link_flit_q};

  always_comb begin
    tx_count_nxt = tx_count;
    rx_count_nxt = rx_count;
    if (tx_push && !tx_pop)      tx_count_nxt = tx_count + CNT_W'(1);
    else if (!tx_push && tx_pop) tx_count_nxt = tx_count - CNT_W'(1);
    if (rx_push && !rx_pop)      rx_count_nxt = rx_count + CNT_W'(1);
    else if (!rx_push && rx_pop) rx_count_nxt = rx_count - CNT_W'(1);
  end

  // Storage arrays carry no reset; validity is tracked by the counters.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_data_i;
    if (rx_push) rx_mem[rx_wr_ptr] <= link_i[FLIT_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_wr_ptr    <= '0;
      tx_rd_ptr    <= '0;
      rx_wr_ptr    <= '0;
      rx_rd_ptr    <= '0;
      tx_count     <= '0;
      rx_count     <= '0;
      link_ready_q <= 1'b0;
      link_valid_q <= 1'b0;
      link_flit_q  <= '0;
      rx_ovf_o     <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
      tx_count <= tx_count_nxt;
      rx_count <= rx_count_nxt;
      // Two free slots keep room for the flit already in flight while ready lags.
      link_ready_q <= (rx_count_nxt <= CNT_W'(DEPTH - 2));
      link_valid_q <= tx_pop;
      if (tx_pop) link_flit_q <= tx_mem[tx_rd_ptr];
      if (rx_drop) rx_ovf_o <= 1'b1;
    end
  end

`ifdef LINK_PORT_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_cnt_o <= '0;
      rx_cnt_o <= '0;
    end else begin
      if (tx_pop)  tx_cnt_o <= tx_cnt_o + 16'd1;
      if (rx_push) rx_cnt_o <= rx_cnt_o + 16'd1;
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_link_port.sv
// Directed bench for link_port: vector table for reset/TX streaming, hand sequences
// for backpressure, RX flow control, overflow and mid-operation reset.
module tb_link_port;

  localparam int unsigned PORT_SIZE = 39;
  localparam int unsigned FLIT_W    = 37;
  localparam logic [38:0] PR = 39'h40_0000_0000;  // ready bit
  localparam logic [38:0] PV = 39'h20_0000_0000;  // valid bit

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [FLIT_W-1:0] tx_data_i = '0;
  logic              tx_valid_i = 1'b0;
  logic              tx_ready_o;
  logic [FLIT_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              rx_ready_i = 1'b0;
  logic [38:0]       link_o;
  logic [38:0]       link_i = '0;
  logic              rx_ovf_o;
`ifdef LINK_PORT_STATS_EN
  logic [15:0]       tx_cnt_o, rx_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  link_port #(.PORT_SIZE(PORT_SIZE), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .link_o(link_o), .link_i(link_i), .rx_ovf_o(rx_ovf_o)
`ifdef LINK_PORT_STATS_EN
    , .tx_cnt_o(tx_cnt_o), .rx_cnt_o(rx_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic        tx_valid;
    logic [36:0] tx_data;
    logic [38:0] link_in;
    logic        exp_tx_ready;
    logic [38:0] exp_link;
    logic        exp_rx_valid;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [38:0] act, input logic [38:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one link-side RX beat (peer ready held high) and advance one edge.
  task automatic rx_beat(input logic v, input logic [36:0] f, input logic rdy);
    link_i     = PR | (v ? PV : 39'h0) | {2'b00, f};
    rx_ready_i = rdy;
    step();
  endtask

  initial begin
    logic [36:0] f;
    logic [36:0] rxq [$];

    vecs[0] = '{1'b1, 1'b0, 37'h0, 39'h0, 1'b0, 39'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 37'h0, PR,    1'b0, 39'h0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 37'h0, PR,    1'b1, PR,    1'b0};
    vecs[3] = '{1'b0, 1'b1, 37'h1_0000_0001, PR, 1'b1, PR, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 37'h1_0000_0002, PR, 1'b1, PR | PV | 39'h1_0000_0001, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 37'h1_0000_0003, PR, 1'b1, PR | PV | 39'h1_0000_0002, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 37'h1_0000_0004, PR, 1'b1, PR | PV | 39'h1_0000_0003, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 37'h0, PR,    1'b1, PR | PV | 39'h1_0000_0004, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 37'h0, PR,    1'b1, PR | 39'h1_0000_0004, 1'b0};

    // Reset release and TX streaming with peer ready
    for (int i = 0; i < 9; i++) begin
      rst_i      = vecs[i].rst;
      tx_valid_i = vecs[i].tx_valid;
      tx_data_i  = vecs[i].tx_data;
      link_i     = vecs[i].link_in;
      step();
      chk($sformatf("vec%0d_tx_ready", i), 39'(tx_ready_o), 39'(vecs[i].exp_tx_ready));
      chk($sformatf("vec%0d_link_o", i), link_o, vecs[i].exp_link);
      chk($sformatf("vec%0d_rx_valid", i), 39'(rx_valid_o), 39'(vecs[i].exp_rx_valid));
      chk($sformatf("vec%0d_rx_ovf", i), 39'(rx_ovf_o), 39'h0);
    end
    tx_valid_i = 1'b0;

    // TX backpressure: peer not ready, fill 4
    link_i = 39'h0;
    for (int i = 0; i < 4; i++) begin
      tx_valid_i = 1'b1;
      tx_data_i  = 37'h0A_0000_0010 + 37'(i);
      step();
      chk($sformatf("bp_fill%0d_valid", i), 39'(link_o[37]), 39'h0);
    end
    tx_valid_i = 1'b0;
    chk("bp_full_tx_ready", 39'(tx_ready_o), 39'h0);
    step();
    chk("bp_hold_valid", 39'(link_o[37]), 39'h0);
    link_i = PR;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("bp_drain%0d_link", i), link_o, PR | PV | {2'b00, 37'h0A_0000_0010 + 37'(i)});
    end
    chk("bp_after_tx_ready", 39'(tx_ready_o), 39'h1);
    step();
    chk("bp_idle_valid", 39'(link_o[37]), 39'h0);

    // RX flow control: 4 flits with switch stalled
    for (int i = 0; i < 4; i++) begin
      f = 37'h15_0000_0100 + 37'(i);
      rx_beat(1'b1, f, 1'b0);
      chk($sformatf("rxfc%0d_link_ready", i), 39'(link_o[38]), (i >= 2) ? 39'h0 : 39'h1);
      chk($sformatf("rxfc%0d_ovf", i), 39'(rx_ovf_o), 39'h0);
    end
    chk("rxfc_head", 39'(rx_data_o), 39'(37'h15_0000_0100));
    // Push with pop at full: no overflow, occupancy unchanged
    rx_beat(1'b1, 37'h15_0000_0104, 1'b1);
    chk("rxfull_pp_ovf", 39'(rx_ovf_o), 39'h0);
    chk("rxfull_pp_ready", 39'(link_o[38]), 39'h0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("rxdrain%0d_valid", i), 39'(rx_valid_o), 39'h1);
      chk($sformatf("rxdrain%0d_data", i), 39'(rx_data_o), 39'(37'h15_0000_0100 + 37'(i)));
      rx_beat(1'b0, 37'h0, 1'b1);
    end
    chk("rxdrain_empty", 39'(rx_valid_o), 39'h0);
    chk("rxdrain_ready", 39'(link_o[38]), 39'h1);

    // RX overflow: fill, then one extra with switch stalled
    for (int i = 0; i < 4; i++) rx_beat(1'b1, 37'h07_0000_0200 + 37'(i), 1'b0);
    chk("ovf_pre", 39'(rx_ovf_o), 39'h0);
    rx_beat(1'b1, 37'h07_DEAD_BEEF, 1'b0);
    chk("ovf_set", 39'(rx_ovf_o), 39'h1);
    rx_beat(1'b0, 37'h0, 1'b0);
    chk("ovf_sticky", 39'(rx_ovf_o), 39'h1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovfdrain%0d_data", i), 39'(rx_data_o), 39'(37'h07_0000_0200 + 37'(i)));
      rx_beat(1'b0, 37'h0, 1'b1);
    end
    chk("ovf_dropped_not_stored", 39'(rx_valid_o), 39'h0);
    chk("ovf_sticky_end", 39'(rx_ovf_o), 39'h1);

    // Mid-operation reset: 2 in TX (peer not ready), 3 in RX
    for (int i = 0; i < 3; i++) begin
      tx_valid_i = (i < 2);
      tx_data_i  = 37'h03_0000_0300 + 37'(i);
      link_i     = PV | {2'b00, 37'h03_0000_0400 + 37'(i)};
      rx_ready_i = 1'b0;
      step();
    end
    tx_valid_i = 1'b0;
    link_i     = 39'h0;
    chk("mid_pre_rx_valid", 39'(rx_valid_o), 39'h1);
    rst_i = 1'b1;
    step();
    chk("mid_rst_link_o", link_o, 39'h0);
    chk("mid_rst_rx_valid", 39'(rx_valid_o), 39'h0);
    chk("mid_rst_tx_ready", 39'(tx_ready_o), 39'h0);
    chk("mid_rst_ovf", 39'(rx_ovf_o), 39'h0);
    rst_i  = 1'b0;
    link_i = PR;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post%0d_tx_ready", i), 39'(tx_ready_o), 39'h1);
      chk($sformatf("post%0d_link_o", i), link_o, PR);
      chk($sformatf("post%0d_rx_valid", i), 39'(rx_valid_o), 39'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
